// File: rtl/val_matrix_sched_if.sv
// rtl/val_matrix_sched_if.sv - requester and matrix-port bundle for val_matrix_sched
interface val_matrix_sched_if #(
  parameter int NREQ = 2,
  parameter int DIM  = 3,
  parameter int DW   = 4,
  parameter int RW   = (DIM > 1) ? $clog2(DIM) : 1
);
  logic [NREQ-1:0]        req_valid;
  logic [NREQ-1:0]        req_ready;
  logic [NREQ*RW-1:0]     req_row;
  logic [NREQ*DIM*DW-1:0] req_data;
  logic                   mat_wr_en;
  logic [RW-1:0]          mat_wr_row;
  logic [DIM*DW-1:0]      mat_wr_data;
  logic                   mat_start;
  logic                   mat_done;
  logic [DIM-1:0]         row_filled;
  logic                   busy;
  logic                   err_drop;
  logic                   timeout;

  modport master (
    output req_valid, req_row, req_data, mat_done,
    input  req_ready, mat_wr_en, mat_wr_row, mat_wr_data, mat_start,
           row_filled, busy, err_drop, timeout
  );

  modport slave (
    input  req_valid, req_row, req_data, mat_done,
    output req_ready, mat_wr_en, mat_wr_row, mat_wr_data, mat_start,
           row_filled, busy, err_drop, timeout
  );
endinterface

// File: rtl/val_matrix_sched.sv
// rtl/val_matrix_sched.sv - round-robin row-write scheduler for the value matrix
// Optional BUSY watchdog enabled by defining VALMAT_SCHED_TIMEOUT_EN.
module val_matrix_sched #(
  parameter int NREQ    = 2,
  parameter int DIM     = 3,
  parameter int DW      = 4,
  parameter int RW      = (DIM > 1) ? $clog2(DIM) : 1,
  parameter int TMO_CYC = 64
) (
  input  logic              clk,
  input  logic              rst,
  val_matrix_sched_if.slave bus
);
  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {FILL, START, BUSY} state_e;

  state_e            state_q, state_d;
  logic [PW-1:0]     rr_ptr_q, rr_ptr_d;
  logic [DIM-1:0]    filled_q, filled_d;
  logic              wr_en_q, wr_en_d;
  logic [RW-1:0]     wr_row_q, wr_row_d;
  logic [DIM*DW-1:0] wr_data_q, wr_data_d;
  logic              start_q, start_d;
  logic              drop_q, drop_d;

  logic              leave;
  logic              gfound;
  logic [PW-1:0]     gidx;
  logic [NREQ-1:0]   grant;
  logic [RW-1:0]     sel_row;
  logic [DIM*DW-1:0] sel_data;
  logic              row_ok;

`ifdef VALMAT_SCHED_TIMEOUT_EN
  localparam int CW = $clog2(TMO_CYC + 1);
  logic [CW-1:0] cnt_q, cnt_d;
  logic          tmo_q, tmo_d;
`endif

  // The last row write is visible on the port this cycle: stop granting now.
  assign leave = (state_q == FILL) && wr_en_q && (&filled_q);

  always_comb begin : arb
    int idx;
    idx    = 0;
    gfound = 1'b0;
    gidx   = '0;
    grant  = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(rr_ptr_q) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!gfound && bus.req_valid[idx]) begin
        gfound = 1'b1;
        gidx   = PW'(idx);
      end
    end
    if ((state_q != FILL) || leave || !rst) gfound = 1'b0;
    if (gfound) grant[gidx] = 1'b1;
  end

  assign sel_row  = bus.req_row[gidx*RW +: RW];
  assign sel_data = bus.req_data[gidx*DIM*DW +: DIM*DW];

  always_comb begin
    row_ok = 1'b0;
    for (int r = 0; r < DIM; r++) begin
      if ((sel_row == RW'(r)) && !filled_q[r]) row_ok = 1'b1;
    end
  end

  always_comb begin
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    filled_d  = filled_q;
    wr_en_d   = 1'b0;
    wr_row_d  = wr_row_q;
    wr_data_d = wr_data_q;
    start_d   = 1'b0;
    drop_d    = 1'b0;
`ifdef VALMAT_SCHED_TIMEOUT_EN
    cnt_d     = cnt_q;
    tmo_d     = 1'b0;
`endif
    case (state_q)
      FILL: begin
        if (leave) begin
          state_d = START;
          start_d = 1'b1;
        end else if (gfound) begin
          rr_ptr_d = (gidx == PW'(NREQ - 1)) ? '0 : gidx + 1'b1;
          if (row_ok) begin
            wr_en_d   = 1'b1;
            wr_row_d  = sel_row;
            wr_data_d = sel_data;
            for (int r = 0; r < DIM; r++) begin
              if (sel_row == RW'(r)) filled_d[r] = 1'b1;
            end
          end else begin
            drop_d = 1'b1;
          end
        end
      end
      START: begin
        state_d = BUSY;
`ifdef VALMAT_SCHED_TIMEOUT_EN
        cnt_d   = '0;
`endif
      end
      BUSY: begin
        if (bus.mat_done) begin
          filled_d = '0;
          state_d  = FILL;
        end
`ifdef VALMAT_SCHED_TIMEOUT_EN
        else if (cnt_q == CW'(TMO_CYC - 1)) begin
          tmo_d    = 1'b1;
          filled_d = '0;
          state_d  = FILL;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= FILL;
      rr_ptr_q  <= '0;
      filled_q  <= '0;
      wr_en_q   <= 1'b0;
      wr_row_q  <= '0;
      wr_data_q <= '0;
      start_q   <= 1'b0;
      drop_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      rr_ptr_q  <= rr_ptr_d;
      filled_q  <= filled_d;
      wr_en_q   <= wr_en_d;
      wr_row_q  <= wr_row_d;
      wr_data_q <= wr_data_d;
      start_q   <= start_d;
      drop_q    <= drop_d;
    end
  end

`ifdef VALMAT_SCHED_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
      tmo_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      tmo_q <= tmo_d;
    end
  end
  assign bus.timeout = tmo_q;
`else
  assign bus.timeout = 1'b0;
`endif

  assign bus.req_ready   = grant;
  assign bus.mat_wr_en   = wr_en_q;
  assign bus.mat_wr_row  = wr_row_q;
  assign bus.mat_wr_data = wr_data_q;
  assign bus.mat_start   = start_q;
  assign bus.row_filled  = filled_q;
  assign bus.busy        = (state_q != FILL);
  assign bus.err_drop    = drop_q;
endmodule
